// File: rtl/button_pkg.sv
// -----------------------------------------------------------------------------
// button_pkg
//   Shared types and helpers for the push-button front end.
//   - deb_state_t : per-channel debounce FSM state encoding (2 bits).
//   - cnt_width() : width of the per-channel stable-cycle counter.
// -----------------------------------------------------------------------------
package button_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,  // settled released, level 0
    PRESS_WAIT   = 2'd1,  // candidate press, counting stable high samples
    HELD         = 2'd2,  // settled pressed, level 1
    RELEASE_WAIT = 2'd3   // candidate release, counting stable low samples
  } deb_state_t;

  // The counter must hold the largest terminal value it is compared against.
  // The repeat period only contributes when auto-repeat is built in.
  function automatic int cnt_width(input int debounce_cycles,
                                   input int repeat_cycles,
                                   input bit use_repeat);
    int span;
    span = debounce_cycles;
    if (use_repeat && (repeat_cycles > debounce_cycles)) begin
      span = repeat_cycles;
    end
    return $clog2(span + 1);
  endfunction

endpackage

// File: rtl/button_conditioner_channel.sv
// -----------------------------------------------------------------------------
// debounce_channel
//   One button channel: 2-flop synchronizer, 4-state debounce FSM and a
//   stable-cycle counter. Emits a registered debounced level and a registered
//   one-cycle pulse on each accepted press (never on release).
//
//   Build option: BUTTON_AUTOREPEAT_EN -- when defined, a held button also
//   produces a pulse every REPEAT_CYCLES cycles after the press pulse.
//
//   Ports
//     clk       : system clock, rising edge
//     rst_n     : asynchronous active-low reset
//     btn_raw   : raw button level, asynchronous, may bounce
//     btn_level : debounced level (registered)
//     btn_pulse : one-cycle press pulse (registered)
// -----------------------------------------------------------------------------
module debounce_channel
  import button_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int REPEAT_CYCLES   = 25_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

`ifdef BUTTON_AUTOREPEAT_EN
  localparam bit USE_REPEAT = 1'b1;
`else
  localparam bit USE_REPEAT = 1'b0;
`endif

  localparam int            CW       = cnt_width(DEBOUNCE_CYCLES, REPEAT_CYCLES, USE_REPEAT);
  localparam logic [CW-1:0] DEB_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef BUTTON_AUTOREPEAT_EN
  localparam logic [CW-1:0] REP_LAST = CW'(REPEAT_CYCLES - 1);
`endif

  logic [1:0]    sync_q;
  logic          sync;
  deb_state_t    state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          level_nxt;
  logic          pulse_nxt;

  assign sync = sync_q[1];

  // Two-flop synchronizer; btn_raw has no timing relationship to clk.
  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_raw};
    end
  end

  // Next-state logic. The counter is cleared or reloaded on every transition
  // and only advances below its terminal compare, so it can never wrap.
  always_comb begin
    // NOTE: every output of this block is defaulted first so no path leaves a
    // signal unassigned, which would otherwise infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    level_nxt = btn_level;
    pulse_nxt = 1'b0;
    unique case (state)
      IDLE: begin
        if (sync) begin
          state_nxt = PRESS_WAIT;
          cnt_nxt   = CW'(1);
        end else begin
          cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sync) begin
          state_nxt = IDLE;       // glitch, no pulse
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = HELD;
          level_nxt = 1'b1;
          pulse_nxt = 1'b1;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!sync) begin
          state_nxt = RELEASE_WAIT;
          cnt_nxt   = CW'(1);
        end else begin
`ifdef BUTTON_AUTOREPEAT_EN
          if (cnt == REP_LAST) begin
            pulse_nxt = 1'b1;
            cnt_nxt   = '0;
          end else begin
            cnt_nxt   = cnt + 1'b1;
          end
`else
          cnt_nxt = '0;
`endif
        end
      end
      RELEASE_WAIT: begin
        if (sync) begin
          state_nxt = HELD;       // release glitch, no new pulse
          cnt_nxt   = '0;
        end else if (cnt == DEB_LAST) begin
          state_nxt = IDLE;
          level_nxt = 1'b0;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt   = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        level_nxt = 1'b0;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      btn_level <= 1'b0;
      btn_pulse <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      btn_level <= level_nxt;
      btn_pulse <= pulse_nxt;
    end
  end

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//   Synchronizes, debounces and edge-detects N_BTN raw push buttons, producing
//   one-cycle command pulses for the accumulator controller (bit 0 -> b1 add
//   request, bit 1 -> b2 acknowledge/clear). Channels are independent;
//   simultaneous presses pulse in the same cycle.
//
//   Build option: BUTTON_AUTOREPEAT_EN -- enables auto-repeat pulses on held
//   buttons every REPEAT_CYCLES cycles.
//
//   Ports
//     clk       : system clock, rising edge
//     rst_n     : asynchronous active-low reset
//     btn_raw   : [N_BTN] raw button levels, active-high, asynchronous
//     btn_level : [N_BTN] debounced registered levels
//     btn_pulse : [N_BTN] one-cycle press pulses
// -----------------------------------------------------------------------------
module button_conditioner
  import button_pkg::*;
#(
  parameter int N_BTN           = 2,
  parameter int DEBOUNCE_CYCLES = 500_000,
  parameter int REPEAT_CYCLES   = 25_000_000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_pulse
);

  for (genvar i = 0; i < N_BTN; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_CYCLES   (REPEAT_CYCLES)
    ) u_ch (
      .clk       (clk),
      .rst_n     (rst_n),
      .btn_raw   (btn_raw[i]),
      .btn_level (btn_level[i]),
      .btn_pulse (btn_pulse[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// -----------------------------------------------------------------------------
// tb_button_conditioner
//   Self-checking bench for button_conditioner with DEBOUNCE_CYCLES=4,
//   REPEAT_CYCLES=8, N_BTN=2. Expected pulses (channel, edge number) are
//   queued when stimulus is applied and matched as the DUT emits pulses.
//   Levels are checked at the edges where they must and must not change.
// -----------------------------------------------------------------------------
module tb_button_conditioner;

  localparam int N_BTN = 2;
  localparam int DEB   = 4;
  localparam int REP   = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [N_BTN-1:0] btn_raw;
  logic [N_BTN-1:0] btn_level;
  logic [N_BTN-1:0] btn_pulse;

  typedef struct {
    int ch;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;   // number of rising edges so far
  int   n_cmp = 0;
  int   n_err = 0;

  button_conditioner #(
    .N_BTN           (N_BTN),
    .DEBOUNCE_CYCLES (DEB),
    .REPEAT_CYCLES   (REP)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_raw   (btn_raw),
    .btn_level (btn_level),
    .btn_pulse (btn_pulse)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", tag, got, exp, cyc);
    end
  endtask

  // Wait until the negedge following rising edge number c.
  task automatic at(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic push_one(input int ch, input int c);
    exp_t e;
    e.ch  = ch;
    e.cyc = c;
    sb.push_back(e);
  endtask

  // Raw high on edges k .. k+n-1 for the channels in mask (n >= DEB).
  // Press pulse after edge k+DEB+1; with auto-repeat, further pulses every
  // REP edges while the FSM still sees the button held (through edge k+n+1).
  task automatic push_hold(input logic [N_BTN-1:0] mask, input int k, input int n);
    int t;
    t = k + DEB + 1;
    for (int c = 0; c < N_BTN; c++) if (mask[c]) push_one(c, t);
`ifdef BUTTON_AUTOREPEAT_EN
    for (t = t + REP; t <= k + n + 1; t += REP) begin
      for (int c = 0; c < N_BTN; c++) if (mask[c]) push_one(c, t);
    end
`endif
  endtask

  // Clean press of n edges (n >= 6) followed by a clean release.
  task automatic do_press(input logic [N_BTN-1:0] mask, input int n);
    int k;
    btn_raw = btn_raw | mask;
    k = cyc + 1;
    push_hold(mask, k, n);
    at(k + DEB);     check("level_before_accept", int'(btn_level & mask), 0);
    at(k + DEB + 1); check("level_rise",          int'(btn_level & mask), int'(mask));
    at(k + n - 1);   btn_raw = btn_raw & ~mask;
    at(k + n + DEB); check("level_before_release", int'(btn_level & mask), int'(mask));
    at(k + n + DEB + 1); check("level_fall",       int'(btn_level & mask), 0);
    at(k + n + DEB + 4);
  endtask

  // Scoreboard monitor: every pulse must match the queue head in edge and
  // channel; entries whose edge has passed were never produced.
  always @(negedge clk) begin
    if (rst_n) begin
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        check("pulse_missing", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      for (int c = 0; c < N_BTN; c++) begin
        if (btn_pulse[c]) begin
          if (sb.size() == 0) begin
            check("pulse_unexpected", int'(btn_pulse[c]), 0);
          end else begin
            check("pulse_edge", cyc, sb[0].cyc);
            check("pulse_channel", c, sb[0].ch);
            void'(sb.pop_front());
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int k, k0, k1, k2;
    rst_n   = 1'b0;
    btn_raw = '0;
    repeat (3) @(negedge clk);
    check("reset_level", int'(btn_level), 0);
    check("reset_pulse", int'(btn_pulse), 0);
    rst_n = 1'b1;
    at(9);

    // Clean press on channel 0, then a longer hold.
    do_press(2'b01, 6);
    do_press(2'b01, 12);

    // Bounce 1,0,1,0 then low: nothing must happen.
    btn_raw[0] = 1'b1; @(negedge clk);
    btn_raw[0] = 1'b0; @(negedge clk);
    btn_raw[0] = 1'b1; @(negedge clk);
    btn_raw[0] = 1'b0;
    repeat (12) @(negedge clk);
    check("bounce_level", int'(btn_level), 0);

    // High for DEB-1 edges: rejected.
    btn_raw[0] = 1'b1; repeat (DEB - 1) @(negedge clk);
    btn_raw[0] = 1'b0; repeat (10) @(negedge clk);
    check("short_press_level", int'(btn_level), 0);

    // High for exactly DEB edges: accepted.
    btn_raw[0] = 1'b1;
    k = cyc + 1;
    push_hold(2'b01, k, DEB);
    at(k + DEB - 1); btn_raw[0] = 1'b0;
    at(k + DEB + 1); check("min_press_level", int'(btn_level[0]), 1);
    at(k + 2*DEB);   check("min_press_hold",  int'(btn_level[0]), 1);
    at(k + 2*DEB + 1); check("min_press_fall", int'(btn_level[0]), 0);
    at(k + 2*DEB + 4);

    // Release glitch of 2 edges while HELD: level stays, no new pulse.
    btn_raw[0] = 1'b1;
    k = cyc + 1;
    push_one(0, k + DEB + 1);
    at(k + 7);  btn_raw[0] = 1'b0;   // low on edges k+8, k+9
    at(k + 9);  btn_raw[0] = 1'b1;
    at(k + 11); check("glitch_level_a", int'(btn_level[0]), 1);
    at(k + 14); check("glitch_level_b", int'(btn_level[0]), 1);
    at(k + 15); btn_raw[0] = 1'b0;   // first low edge k+16
    at(k + 20); check("glitch_release_hold", int'(btn_level[0]), 1);
    at(k + 21); check("glitch_release_fall", int'(btn_level[0]), 0);
    at(k + 24);

    // Simultaneous press on both channels.
    do_press(2'b11, 6);

    // Reset: channel 1 held (level 1), channel 0 mid-count in PRESS_WAIT.
    btn_raw[1] = 1'b1;
    k1 = cyc + 1;
    push_one(1, k1 + DEB + 1);
    at(k1 + 7);
    btn_raw[0] = 1'b1;
    k0 = k1 + 8;
    at(k0 + 3);
    check("pre_reset_level", int'(btn_level), 2);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    check("async_reset_level", int'(btn_level), 0);
    check("async_reset_pulse", int'(btn_pulse), 0);
    repeat (2) @(negedge clk);
    check("in_reset_level", int'(btn_level), 0);
    rst_n = 1'b1;
    k2 = cyc + 1;
    push_hold(2'b11, k2, 6);
    at(k2 + DEB);     check("post_reset_pre",  int'(btn_level), 0);
    at(k2 + DEB + 1); check("post_reset_rise", int'(btn_level), 3);
    btn_raw = '0;     // first low edge k2+6
    at(k2 + 6 + DEB); check("post_reset_hold", int'(btn_level), 3);
    at(k2 + 7 + DEB); check("post_reset_fall", int'(btn_level), 0);
    at(k2 + 14);

    // Long hold: one pulse, or repeats every REP edges with auto-repeat.
    do_press(2'b01, 30);

    repeat (5) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
